// File: rtl/fb_slave_pkg.sv
// Shared FREEDM-bus slave receive constants: start-of-frame codes and the nibble counts
// of each frame section. fb_slave_statem and the master side also use this package.
package fb_slave_pkg;

  localparam logic [3:0] PREAMBLE_NIB  = 4'h5;
  localparam logic [3:0] SOC_DATA      = 4'hD;
  localparam logic [3:0] SOC_NUMB      = 4'h9;
  localparam logic [3:0] SOC_DIST      = 4'hA;
  localparam logic [3:0] SOC_DELAY     = 4'hB;
  localparam logic [3:0] SOC_DELAYDIST = 4'hC;

  localparam int unsigned HDR_NIB     = 2;
  localparam int unsigned DATA_NIB    = 16;
  localparam int unsigned CRC_NIB     = 4;
  localparam int unsigned NUMB_NIB    = 4;
  localparam int unsigned DELAY_NIB   = 4;
  localparam int unsigned DIST_NIB    = 8;
  localparam int unsigned FRM_CRC_NIB = 8;
  localparam int unsigned CNT_W       = 12;

  localparam int unsigned BLK       = HDR_NIB + DATA_NIB + CRC_NIB;
  localparam int unsigned FRM_CRC_W = $clog2(FRM_CRC_NIB + 1);

  typedef logic [CNT_W-1:0] nib_cnt_t;

  // Index of the last nibble of a data frame; a slave count of 0 is treated as 1.
  function automatic nib_cnt_t frame_last_idx(input logic [3:0] num_slaves);
    int unsigned n;
    n = (num_slaves == 4'd0) ? 1 : int'(num_slaves);
    return nib_cnt_t'(n * BLK - 1);
  endfunction

endpackage

// File: rtl/fb_slave_nibcnt_if.sv
// Receive-side signal bundle between fb_slave_statem and fb_slave_nibcnt.
// The slave modport is the nibble counter's view; master is the state machine's view.
interface fb_slave_nibcnt_if import fb_slave_pkg::*; ();

  logic       MRxDV;
  logic [3:0] MRxD;
  logic [3:0] NumSlaves;

  logic       StateIdle;
  logic       StateFFS;
  logic       StatePreamble;
  logic       StateNumb;
  logic       StateDist;
  logic       StateDelay;
  logic       StateDelayDist;
  logic       StateData;
  logic       StateSlaveCrc;
  logic       StateFrmCrc;
  logic [1:0] StateSlaveData;

  logic       MRxDEq5;
  logic       MRxDEqDataSoC;
  logic       MRxDEqNumbSoC;
  logic       MRxDEqDistSoC;
  logic       MRxDEqDelaySoC;
  logic       MRxDEqDelayDistSoC;

  logic       SlaveIDStart;
  logic       DelayMeasStart;
  logic       DistStateEnd;
  logic       DelayDistStateEnd;
  logic       SlaveDataStart;
  logic       SlaveDataEnd;
  logic       SlaveCrcEnd;
  logic       IsLastSlave;
  logic       DataFrameEnd;
  logic       FrmCrcStateEnd;

  nib_cnt_t   TotalNibCnt;
  logic [3:0] SlaveCnt;

  modport slave (
    input  MRxDV, MRxD, NumSlaves,
    input  StateIdle, StateFFS, StatePreamble, StateNumb, StateDist, StateDelay,
    input  StateDelayDist, StateData, StateSlaveCrc, StateFrmCrc, StateSlaveData,
    output MRxDEq5, MRxDEqDataSoC, MRxDEqNumbSoC, MRxDEqDistSoC, MRxDEqDelaySoC,
    output MRxDEqDelayDistSoC,
    output SlaveIDStart, DelayMeasStart, DistStateEnd, DelayDistStateEnd,
    output SlaveDataStart, SlaveDataEnd, SlaveCrcEnd, IsLastSlave, DataFrameEnd,
    output FrmCrcStateEnd, TotalNibCnt, SlaveCnt
  );

  modport master (
    output MRxDV, MRxD, NumSlaves,
    output StateIdle, StateFFS, StatePreamble, StateNumb, StateDist, StateDelay,
    output StateDelayDist, StateData, StateSlaveCrc, StateFrmCrc, StateSlaveData,
    input  MRxDEq5, MRxDEqDataSoC, MRxDEqNumbSoC, MRxDEqDistSoC, MRxDEqDelaySoC,
    input  MRxDEqDelayDistSoC,
    input  SlaveIDStart, DelayMeasStart, DistStateEnd, DelayDistStateEnd,
    input  SlaveDataStart, SlaveDataEnd, SlaveCrcEnd, IsLastSlave, DataFrameEnd,
    input  FrmCrcStateEnd, TotalNibCnt, SlaveCnt
  );

endinterface

// File: rtl/fb_slave_soc_decode.sv
// Purely combinational compares of the received nibble against preamble and SoC codes.
module fb_slave_soc_decode import fb_slave_pkg::*; (
  input  logic [3:0] MRxD,
  output logic       MRxDEq5,
  output logic       MRxDEqDataSoC,
  output logic       MRxDEqNumbSoC,
  output logic       MRxDEqDistSoC,
  output logic       MRxDEqDelaySoC,
  output logic       MRxDEqDelayDistSoC
);

  always_comb begin
    MRxDEq5            = (MRxD == PREAMBLE_NIB);
    MRxDEqDataSoC      = (MRxD == SOC_DATA);
    MRxDEqNumbSoC      = (MRxD == SOC_NUMB);
    MRxDEqDistSoC      = (MRxD == SOC_DIST);
    MRxDEqDelaySoC     = (MRxD == SOC_DELAY);
    MRxDEqDelayDistSoC = (MRxD == SOC_DELAYDIST);
  end

endmodule

// File: rtl/fb_slave_nibcnt.sv
// Nibble counters and end/start strobes for the FREEDM-bus slave receive state machine.
// Every strobe is a zero-latency compare against registered counters.
module fb_slave_nibcnt import fb_slave_pkg::*; (
  input  logic                MRxClk,
  input  logic                Reset_n,
  fb_slave_nibcnt_if.slave    bus
);

  localparam nib_cnt_t NUMB_LAST  = nib_cnt_t'(NUMB_NIB - 1);
  localparam nib_cnt_t DELAY_LAST = nib_cnt_t'(DELAY_NIB - 1);
  localparam nib_cnt_t DIST_LAST  = nib_cnt_t'(DIST_NIB - 1);
  localparam nib_cnt_t HDR_LAST   = nib_cnt_t'(HDR_NIB - 1);
  localparam nib_cnt_t DATA_LAST  = nib_cnt_t'(HDR_NIB + DATA_NIB - 1);
  localparam nib_cnt_t BLK_LAST   = nib_cnt_t'(BLK - 1);
  localparam nib_cnt_t BLK_STEP   = nib_cnt_t'(BLK);
  localparam logic [FRM_CRC_W-1:0] FRM_CRC_LAST = FRM_CRC_W'(FRM_CRC_NIB - 1);

  nib_cnt_t             total_nib_cnt_d, total_nib_cnt_q;
  nib_cnt_t             slave_base_d, slave_base_q;
  nib_cnt_t             frame_last_d, frame_last_q;
  logic [3:0]           slave_cnt_d, slave_cnt_q;
  logic [FRM_CRC_W-1:0] frm_crc_cnt_d, frm_crc_cnt_q;
  logic [3:0]           num_slaves_eff;
  logic                 cnt_clr;
  logic                 slave_crc_end;
  logic                 slave_adv;

  // These state inputs are part of the shared bundle but no compare depends on them.
  logic unused_state;
  assign unused_state = ^{bus.StateData, bus.StateSlaveData};

  fb_slave_soc_decode u_soc_decode (
    .MRxD               (bus.MRxD),
    .MRxDEq5            (bus.MRxDEq5),
    .MRxDEqDataSoC      (bus.MRxDEqDataSoC),
    .MRxDEqNumbSoC      (bus.MRxDEqNumbSoC),
    .MRxDEqDistSoC      (bus.MRxDEqDistSoC),
    .MRxDEqDelaySoC     (bus.MRxDEqDelaySoC),
    .MRxDEqDelayDistSoC (bus.MRxDEqDelayDistSoC)
  );

  always_comb begin
    cnt_clr        = bus.StateIdle | bus.StateFFS | bus.StatePreamble;
    slave_crc_end  = (total_nib_cnt_q == slave_base_q + BLK_LAST);
    slave_adv      = bus.StateSlaveCrc & slave_crc_end & bus.MRxDV;
    num_slaves_eff = (bus.NumSlaves == 4'd0) ? 4'd1 : bus.NumSlaves;
  end

  // Slave block base is a running sum stepped by BLK, so no multiplier sits in the compare path.
  always_comb begin
    total_nib_cnt_d = total_nib_cnt_q;
    slave_cnt_d     = slave_cnt_q;
    slave_base_d    = slave_base_q;
    if (cnt_clr) begin
      total_nib_cnt_d = '0;
      slave_cnt_d     = '0;
      slave_base_d    = '0;
    end else begin
      if (bus.MRxDV && (total_nib_cnt_q != '1)) begin
        total_nib_cnt_d = total_nib_cnt_q + nib_cnt_t'(1);
      end
      if (slave_adv) begin
        slave_cnt_d  = slave_cnt_q + 4'd1;
        slave_base_d = slave_base_q + BLK_STEP;
      end
    end
    frame_last_d = bus.StatePreamble ? frame_last_idx(bus.NumSlaves) : frame_last_q;
    if (!bus.StateFrmCrc) begin
      frm_crc_cnt_d = '0;
    end else if (bus.MRxDV) begin
      frm_crc_cnt_d = frm_crc_cnt_q + FRM_CRC_W'(1);
    end else begin
      frm_crc_cnt_d = frm_crc_cnt_q;
    end
  end

  // Frame end index resets to all-ones so DataFrameEnd stays low until a preamble loads it.
  always_ff @(posedge MRxClk or negedge Reset_n) begin
    if (!Reset_n) begin
      total_nib_cnt_q <= '0;
      slave_cnt_q     <= '0;
      slave_base_q    <= '0;
      frame_last_q    <= '1;
      frm_crc_cnt_q   <= '0;
    end else begin
      total_nib_cnt_q <= total_nib_cnt_d;
      slave_cnt_q     <= slave_cnt_d;
      slave_base_q    <= slave_base_d;
      frame_last_q    <= frame_last_d;
      frm_crc_cnt_q   <= frm_crc_cnt_d;
    end
  end

  always_comb begin
    bus.TotalNibCnt       = total_nib_cnt_q;
    bus.SlaveCnt          = slave_cnt_q;
    bus.SlaveIDStart      = bus.StateNumb      & (total_nib_cnt_q == NUMB_LAST);
    bus.DelayMeasStart    = bus.StateDelay     & (total_nib_cnt_q == DELAY_LAST);
    bus.DistStateEnd      = bus.StateDist      & (total_nib_cnt_q == DIST_LAST);
    bus.DelayDistStateEnd = bus.StateDelayDist & (total_nib_cnt_q == DIST_LAST);
    bus.SlaveDataStart    = (total_nib_cnt_q == slave_base_q + HDR_LAST);
    bus.SlaveDataEnd      = (total_nib_cnt_q == slave_base_q + DATA_LAST);
    bus.SlaveCrcEnd       = slave_crc_end;
    bus.IsLastSlave       = (slave_cnt_q == num_slaves_eff - 4'd1);
    bus.DataFrameEnd      = (total_nib_cnt_q == frame_last_q);
    bus.FrmCrcStateEnd    = bus.StateFrmCrc & bus.MRxDV & (frm_crc_cnt_q == FRM_CRC_LAST);
  end

endmodule

// File: tb/tb_fb_slave_nibcnt.sv
// Bench for fb_slave_nibcnt: directed frames plus randomized traffic, checked every cycle
// against a behavioural nibble-count model, with literal expectations for key strobe indices.
module tb_fb_slave_nibcnt;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fb_slave_nibcnt_if bus ();

  fb_slave_nibcnt dut (
    .MRxClk  (clk),
    .Reset_n (rst_n),
    .bus     (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cnt = 0;     // valid nibbles since last clear, saturating at 4095
  int m_n = 0;       // completed slave blocks since last clear
  int m_fend = 0;    // last nibble index of the data frame
  bit m_fvalid = 0;  // a preamble has set m_fend since reset
  int m_frm = 0;     // valid frame-CRC nibbles seen in the current StateFrmCrc stretch

  function automatic int ns_eff();
    return (bus.NumSlaves == 4'd0) ? 1 : int'(bus.NumSlaves);
  endfunction

  function automatic int blk_idx(input int off);
    return (m_n * 22 + off) % 4096;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit crc_end;
    if (!rst_n) begin
      m_cnt = 0; m_n = 0; m_frm = 0; m_fvalid = 0; m_fend = 0;
    end else begin
      crc_end = (m_cnt == blk_idx(21));
      if (bus.StatePreamble) begin
        m_fend = ns_eff() * 22 - 1;
        m_fvalid = 1;
      end
      if (bus.StateIdle || bus.StateFFS || bus.StatePreamble) begin
        m_cnt = 0;
        m_n = 0;
      end else begin
        if (bus.StateSlaveCrc && crc_end && bus.MRxDV) m_n = m_n + 1;
        if (bus.MRxDV && m_cnt < 4095) m_cnt = m_cnt + 1;
      end
      if (!bus.StateFrmCrc) m_frm = 0;
      else if (bus.MRxDV) m_frm = (m_frm + 1) % 16;
    end
  end

  always @(negedge clk) begin : compare
    chk("TotalNibCnt", bus.TotalNibCnt, m_cnt);
    chk("SlaveCnt", bus.SlaveCnt, m_n % 16);
    chk("SlaveIDStart", bus.SlaveIDStart, bus.StateNumb && m_cnt == 3);
    chk("DelayMeasStart", bus.DelayMeasStart, bus.StateDelay && m_cnt == 3);
    chk("DistStateEnd", bus.DistStateEnd, bus.StateDist && m_cnt == 7);
    chk("DelayDistStateEnd", bus.DelayDistStateEnd, bus.StateDelayDist && m_cnt == 7);
    chk("SlaveDataStart", bus.SlaveDataStart, m_cnt == blk_idx(1));
    chk("SlaveDataEnd", bus.SlaveDataEnd, m_cnt == blk_idx(17));
    chk("SlaveCrcEnd", bus.SlaveCrcEnd, m_cnt == blk_idx(21));
    chk("IsLastSlave", bus.IsLastSlave, (m_n % 16) == ns_eff() - 1);
    chk("DataFrameEnd", bus.DataFrameEnd, m_fvalid && m_cnt == m_fend);
    chk("FrmCrcStateEnd", bus.FrmCrcStateEnd, bus.StateFrmCrc && bus.MRxDV && m_frm == 7);
    chk("MRxDEq5", bus.MRxDEq5, bus.MRxD == 4'h5);
    chk("MRxDEqDataSoC", bus.MRxDEqDataSoC, bus.MRxD == 4'hD);
    chk("MRxDEqNumbSoC", bus.MRxDEqNumbSoC, bus.MRxD == 4'h9);
    chk("MRxDEqDistSoC", bus.MRxDEqDistSoC, bus.MRxD == 4'hA);
    chk("MRxDEqDelaySoC", bus.MRxDEqDelaySoC, bus.MRxD == 4'hB);
    chk("MRxDEqDelayDistSoC", bus.MRxDEqDelayDistSoC, bus.MRxD == 4'hC);
  end

  // ---------------- stimulus helpers ----------------
  int q_sds[$], q_sde[$], q_sce[$], q_dfe[$], q_frm[$], q_sid[$];
  int last_first;

  function automatic int qat(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  task automatic clr_st();
    bus.StateIdle = 0; bus.StateFFS = 0; bus.StatePreamble = 0; bus.StateNumb = 0;
    bus.StateDist = 0; bus.StateDelay = 0; bus.StateDelayDist = 0; bus.StateData = 0;
    bus.StateSlaveCrc = 0; bus.StateFrmCrc = 0; bus.StateSlaveData = 2'd0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic nib(input logic dv, input logic [3:0] d);
    bus.MRxDV = dv;
    bus.MRxD = d;
    @(negedge clk);
    #1;
  endtask

  task automatic data_states(input int i);
    clr_st();
    bus.StateData = 1;
    bus.StateSlaveCrc = (i % 22) >= 18;
    bus.StateSlaveData = ((i % 22) < 2) ? 2'd0 : ((i % 22) < 18) ? 2'd1 : 2'd2;
  endtask

  task automatic preamble(input logic [3:0] soc);
    nxt(); clr_st(); bus.StateIdle = 1; nib(0, 4'h0);
    repeat (3) begin
      nxt(); clr_st(); bus.StatePreamble = 1; nib(1, 4'h5);
      chk("preamble_decode", bus.MRxDEq5, 1);
    end
    nxt(); clr_st(); bus.StatePreamble = 1; nib(1, soc);
    if (soc == 4'h9) chk("numb_soc_decode", bus.MRxDEqNumbSoC, 1);
    if (soc == 4'hD) chk("data_soc_decode", bus.MRxDEqDataSoC, 1);
  endtask

  task automatic data_frame(input logic [3:0] ns, input int gap_at, input int rst_at);
    int len;
    bus.NumSlaves = ns;
    preamble(4'hD);
    q_sds.delete(); q_sde.delete(); q_sce.delete(); q_dfe.delete();
    last_first = -1;
    len = ((ns == 0) ? 1 : int'(ns)) * 22;
    for (int i = 0; i < len; i++) begin
      if (i == gap_at) begin
        repeat (3) begin
          nxt(); data_states(i); nib(0, 4'h0);
          chk("gap_hold", bus.TotalNibCnt, i);
        end
      end
      nxt(); data_states(i); nib(1, 4'($urandom));
      chk("frame_idx", bus.TotalNibCnt, i);
      if (bus.SlaveDataStart) q_sds.push_back(i);
      if (bus.SlaveDataEnd) q_sde.push_back(i);
      if (bus.SlaveCrcEnd) q_sce.push_back(i);
      if (bus.DataFrameEnd) q_dfe.push_back(i);
      if (bus.IsLastSlave && last_first < 0) last_first = i;
      if (i == rst_at) begin
        #1 rst_n = 0;
        #1;
        chk("rst_total", bus.TotalNibCnt, 0);
        chk("rst_slavecnt", bus.SlaveCnt, 0);
        chk("rst_strobes", {bus.SlaveIDStart, bus.DelayMeasStart, bus.DistStateEnd,
                            bus.DelayDistStateEnd, bus.SlaveDataStart, bus.SlaveDataEnd,
                            bus.SlaveCrcEnd, bus.IsLastSlave, bus.DataFrameEnd,
                            bus.FrmCrcStateEnd}, 0);
        return;
      end
    end
  endtask

  task automatic frm_crc(input int exp_sc);
    q_frm.delete();
    for (int k = 1; k <= 8; k++) begin
      nxt(); clr_st(); bus.StateFrmCrc = 1; nib(1, 4'($urandom));
      if (k == 1) chk("slavecnt_after_frame", bus.SlaveCnt, exp_sc);
      if (bus.FrmCrcStateEnd) q_frm.push_back(k);
    end
    chk("frmcrc_end_count", q_frm.size(), 1);
    chk("frmcrc_end_at", qat(q_frm, 0), 8);
    nxt(); clr_st(); bus.StateIdle = 1; nib(0, 4'h0);
  endtask

  task automatic check_ns2_frame(input string tag);
    chk({tag, "_sds_n"}, q_sds.size(), 2);
    chk({tag, "_sds0"}, qat(q_sds, 0), 1);
    chk({tag, "_sds1"}, qat(q_sds, 1), 23);
    chk({tag, "_sde0"}, qat(q_sde, 0), 17);
    chk({tag, "_sde1"}, qat(q_sde, 1), 39);
    chk({tag, "_sce0"}, qat(q_sce, 0), 21);
    chk({tag, "_sce1"}, qat(q_sce, 1), 43);
    chk({tag, "_dfe_n"}, q_dfe.size(), 1);
    chk({tag, "_dfe0"}, qat(q_dfe, 0), 43);
    chk({tag, "_last_first"}, last_first, 22);
  endtask

  initial begin
    clr_st();
    bus.StateIdle = 1;
    bus.MRxDV = 0;
    bus.MRxD = 4'h0;
    bus.NumSlaves = 4'd2;
    @(negedge clk);
    #1;
    chk("reset_total", bus.TotalNibCnt, 0);
    chk("reset_dfe", bus.DataFrameEnd, 0);
    nxt(); nxt();
    rst_n = 1;

    // Numbering frame: SlaveIDStart exactly once, at index 3.
    preamble(4'h9);
    q_sid.delete();
    for (int i = 0; i < 6; i++) begin
      nxt(); clr_st(); bus.StateNumb = 1; nib(1, 4'($urandom));
      if (bus.SlaveIDStart) q_sid.push_back(int'(bus.TotalNibCnt));
    end
    chk("sid_count", q_sid.size(), 1);
    chk("sid_at", qat(q_sid, 0), 3);

    // Two-slave data frame followed by two frame-CRC passes.
    data_frame(4'd2, -1, -1);
    check_ns2_frame("df2");
    frm_crc(2);
    frm_crc(0);

    // Same frame with a three-cycle MRxDV gap at index 10.
    data_frame(4'd2, 10, -1);
    check_ns2_frame("gap");
    frm_crc(2);

    // NumSlaves=0 acts as a single slave.
    data_frame(4'd0, -1, -1);
    chk("ns0_last_first", last_first, 0);
    chk("ns0_dfe_n", q_dfe.size(), 1);
    chk("ns0_dfe0", qat(q_dfe, 0), 21);
    chk("ns0_sce0", qat(q_sce, 0), 21);

    // Asynchronous reset in the middle of a frame at index 37.
    data_frame(4'd2, -1, 37);
    nxt(); nxt();
    rst_n = 1;

    // Saturation of the nibble counter.
    bus.NumSlaves = 4'd3;
    preamble(4'hD);
    for (int i = 0; i < 4100; i++) begin
      nxt(); clr_st(); bus.StateData = 1; nib(1, 4'($urandom));
    end
    chk("saturate", bus.TotalNibCnt, 4095);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      nxt();
      clr_st();
      bus.StateIdle      = ($urandom_range(0, 299) == 0);
      bus.StateFFS       = ($urandom_range(0, 299) == 0);
      bus.StatePreamble  = ($urandom_range(0, 199) == 0);
      bus.StateNumb      = ($urandom_range(0, 3) == 0);
      bus.StateDist      = ($urandom_range(0, 3) == 0);
      bus.StateDelay     = ($urandom_range(0, 3) == 0);
      bus.StateDelayDist = ($urandom_range(0, 3) == 0);
      bus.StateData      = ($urandom_range(0, 1) == 0);
      bus.StateSlaveCrc  = ($urandom_range(0, 1) == 0);
      bus.StateFrmCrc    = ($urandom_range(0, 2) != 0);
      bus.StateSlaveData = 2'($urandom);
      if ($urandom_range(0, 49) == 0) bus.NumSlaves = 4'($urandom);
      nib(($urandom_range(0, 3) != 0), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fb_slave_nibcnt.md
Name: fb_slave_nibcnt

Overview:
- Timing and decode front-end for the FREEDM-bus slave receive state machine (fb_slave_statem), one per slave receive port.
- Decodes the incoming nibble stream (preamble, start-of-frame codes).
- Counts nibbles from start of frame and tracks the current slave block of a data frame.
- Generates every end/start strobe the state machine consumes: zero-latency compares against registered counters.

Parameters:
- SOC_DATA, 4'hD, start-of-frame code: data frame
- SOC_NUMB, 4'h9, start-of-frame code: numbering frame
- SOC_DIST, 4'hA, start-of-frame code: distribution frame
- SOC_DELAY, 4'hB, start-of-frame code: delay frame
- SOC_DELAYDIST, 4'hC, start-of-frame code: delay-distribution frame
- HDR_NIB, 2, header nibbles per slave block (≥1)
- DATA_NIB, 16, data nibbles per slave block (even, ≥2)
- CRC_NIB, 4, CRC nibbles per slave block
- NUMB_NIB, 4, numbering payload nibbles
- DELAY_NIB, 4, delay payload nibbles
- DIST_NIB, 8, distribution and delay-dist payload nibbles
- FRM_CRC_NIB, 8, frame CRC nibbles
- CNT_W, 12, TotalNibCnt width

Ports:
- MRxClk, in, 1: receive clock
- Reset_n, in, 1: asynchronous active-low reset
- MRxDV, in, 1: nibble valid
- MRxD, in, 4: received nibble
- NumSlaves, in, 4: configured slaves per data frame; 0 is treated as 1
- StateIdle, in, 1: state input from fb_slave_statem
- StateFFS, in, 1: state input from fb_slave_statem
- StatePreamble, in, 1: state input from fb_slave_statem
- StateNumb, in, 1: state input from fb_slave_statem
- StateDist, in, 1: state input from fb_slave_statem
- StateDelay, in, 1: state input from fb_slave_statem
- StateDelayDist, in, 1: state input from fb_slave_statem
- StateData, in, 1: state input from fb_slave_statem
- StateSlaveCrc, in, 1: state input from fb_slave_statem
- StateFrmCrc, in, 1: state input from fb_slave_statem
- StateSlaveData, in, 2: state input from fb_slave_statem
- MRxDEq5, out, 1: MRxD==5
- MRxDEqDataSoC, MRxDEqNumbSoC, MRxDEqDistSoC, MRxDEqDelaySoC, MRxDEqDelayDistSoC, out, 1 each: MRxD equals the matching SOC code
- SlaveIDStart, DelayMeasStart, DistStateEnd, DelayDistStateEnd, out, 1 each: payload end strobes
- SlaveDataStart, SlaveDataEnd, SlaveCrcEnd, IsLastSlave, DataFrameEnd, FrmCrcStateEnd, out, 1 each: data-frame strobes
- TotalNibCnt, out, CNT_W: nibble index since SoC
- SlaveCnt, out, 4: current slave block index

Behaviour:
- Reset_n low, asynchronously: TotalNibCnt=0, SlaveCnt=0, SlaveBase=0, FrmCrcCnt=0. All strobes are then 0, except the MRxD-equality decodes, which stay purely combinational on MRxD.
- TotalNibCnt:
  - Cleared on any cycle with StateIdle|StateFFS|StatePreamble.
  - Otherwise increments when MRxDV=1; holds when MRxDV=0.
  - Saturates at all-ones and never wraps.
  - The first nibble after the SoC nibble has index 0.
- SlaveCnt and SlaveBase (a registered running sum, no multiplier):
  - Cleared with TotalNibCnt.
  - On StateSlaveCrc & SlaveCrcEnd & MRxDV: SlaveCnt+=1 and SlaveBase+=BLK, where BLK=HDR_NIB+DATA_NIB+CRC_NIB.
- Strobe compares (combinational on registered counters):
  - SlaveIDStart = StateNumb & TotalNibCnt==NUMB_NIB-1
  - DelayMeasStart = StateDelay & TotalNibCnt==DELAY_NIB-1
  - DistStateEnd = StateDist & TotalNibCnt==DIST_NIB-1
  - DelayDistStateEnd = StateDelayDist & TotalNibCnt==DIST_NIB-1
  - SlaveDataStart = TotalNibCnt==SlaveBase+HDR_NIB-1
  - SlaveDataEnd = TotalNibCnt==SlaveBase+HDR_NIB+DATA_NIB-1
  - SlaveCrcEnd = TotalNibCnt==SlaveBase+BLK-1
  - IsLastSlave = SlaveCnt==max(NumSlaves,1)-1
  - DataFrameEnd = TotalNibCnt==max(NumSlaves,1)*BLK-1 (constant-multiply, registered on StatePreamble)
- FrmCrcCnt:
  - Cleared whenever StateFrmCrc=0; increments on MRxDV while StateFrmCrc.
  - FrmCrcStateEnd = StateFrmCrc & MRxDV & FrmCrcCnt==FRM_CRC_NIB-1.
- MRxDV drop mid-frame: counters hold; strobes may stay asserted, and the state machine handles idle return.
- Reset mid-frame: all counters zero immediately.
- Simultaneous clear and increment conditions: clear wins.

Decomposition:
- Package fb_slave_pkg holds:
  - the SOC codes and the preamble code 4'h5;
  - the nibble-count constants and BLK;
  - shared with fb_slave_statem and the master side.
- One sub-module is natural: fb_slave_soc_decode, combinational MRxD compares only.

Test Plan:
- Reset: drive Reset_n=0 mid-count at TotalNibCnt=37 → TotalNibCnt=0 and SlaveCnt=0 without a clock edge; all strobes 0.
- Numbering frame: StatePreamble with SoC 9, then StateNumb for 4 nibbles → SlaveIDStart high exactly when TotalNibCnt=3, one cycle only.
- Data frame with NumSlaves=2, BLK=22:
  - SlaveDataStart at 1 and 23.
  - SlaveDataEnd at 17 and 39.
  - SlaveCrcEnd at 21 and 43.
  - IsLastSlave rises after the first CRC end.
  - DataFrameEnd at 43.
- MRxDV gaps: deassert MRxDV for 3 cycles at TotalNibCnt=10 → count holds at 10 and resumes at 11; strobe indices are unchanged.
- NumSlaves=0 → behaves as 1: IsLastSlave=1 from frame start, DataFrameEnd at 21.
- Frame CRC: StateFrmCrc for 8 valid nibbles → FrmCrcStateEnd on the 8th only; FrmCrcCnt=0 after exit.
